// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared types, defaults and line compare for the L2 pmem arbiter
package pmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L2_READ,
    L2_WRITE,
    EWB_WRITE,
    EWB_DONE,
    RECOVER
  } pmem_arb_state_t;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned LINE_W_DEF       = 256;
  localparam int unsigned OFFSET_W_DEF     = 5;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // True when both byte addresses fall in the same cache line.
  function automatic logic line_addr_match(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned offset_w);
    return (a >> offset_w) == (b >> offset_w);
  endfunction

endpackage

// File: rtl/pmem_arb_starve_counter.sv
// rtl/pmem_arb_starve_counter.sv - saturating count of L2 grants taken while the EWB waits
module pmem_arb_starve_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == CNT_W'(LIMIT));

  // Clear wins over increment; the count holds once it reaches the limit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/l2_pmem_arbiter.sv
// rtl/l2_pmem_arbiter.sv - arbitrates the pmem port between L2 misses and the eviction write buffer
module l2_pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned LINE_W       = LINE_W_DEF,
  parameter int unsigned OFFSET_W     = OFFSET_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_pmem_read,
  input  logic              l2_pmem_write,
  input  logic [ADDR_W-1:0] l2_pmem_address,
  input  logic [LINE_W-1:0] l2_pmem_wdata,
  output logic [LINE_W-1:0] l2_pmem_rdata,
  output logic              l2_pmem_resp,
  input  logic              ewb_valid,
  input  logic [ADDR_W-1:0] ewb_address,
  input  logic [LINE_W-1:0] ewb_wdata,
  output logic              ewb_done,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pmem_arb_state_t   state;
  pmem_arb_state_t   next_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              hazard;
  logic              starve_at_limit;
  logic              l2_grant;
  logic              ewb_grant;

  // Priority decision evaluated while IDLE: ordering hazards first, then starvation relief.
  always_comb begin
    hazard     = l2_pmem_read && ewb_valid &&
                 line_addr_match(64'(l2_pmem_address), 64'(ewb_address), OFFSET_W);
    next_grant = IDLE;
    if (hazard) begin
      next_grant = EWB_WRITE;
    end else if (l2_pmem_write && ewb_valid) begin
      next_grant = EWB_WRITE;
    end else if (ewb_valid && starve_at_limit) begin
      next_grant = EWB_WRITE;
    end else if (l2_pmem_read) begin
      next_grant = L2_READ;
    end else if (l2_pmem_write) begin
      next_grant = L2_WRITE;
    end else if (ewb_valid) begin
      next_grant = EWB_WRITE;
    end
  end

  assign l2_grant  = (state == IDLE) && ((next_grant == L2_READ) || (next_grant == L2_WRITE));
  assign ewb_grant = (state == IDLE) && (next_grant == EWB_WRITE);

  pmem_arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (l2_grant && ewb_valid),
    .clr     (ewb_grant || !ewb_valid),
    .at_limit(starve_at_limit)
  );

  // Grant FSM: latches the winner and drives registered pmem commands and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      ewb_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (next_grant)
            L2_READ: begin
              state     <= L2_READ;
              addr_q    <= l2_pmem_address;
              wdata_q   <= l2_pmem_wdata;
              pmem_read <= 1'b1;
            end
            L2_WRITE: begin
              state      <= L2_WRITE;
              addr_q     <= l2_pmem_address;
              wdata_q    <= l2_pmem_wdata;
              pmem_write <= 1'b1;
            end
            EWB_WRITE: begin
              state      <= EWB_WRITE;
              addr_q     <= ewb_address;
              wdata_q    <= ewb_wdata;
              pmem_write <= 1'b1;
            end
            default: ;
          endcase
        end
        L2_READ, L2_WRITE: begin
          if (pmem_resp) begin
            state      <= RECOVER;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        EWB_WRITE: begin
          if (pmem_resp) begin
            state      <= EWB_DONE;
            pmem_write <= 1'b0;
            ewb_done   <= 1'b1;
          end
        end
        EWB_DONE: begin
          state    <= RECOVER;
          ewb_done <= 1'b0;
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_address  = addr_q;
  assign pmem_wdata    = wdata_q;
  assign l2_pmem_rdata = pmem_rdata;
  assign l2_pmem_resp  = ((state == L2_READ) || (state == L2_WRITE)) && pmem_resp;

  // L2 must never request a read and a write together; the read is served regardless.
  a_l2_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
                                       !(l2_pmem_read && l2_pmem_write))
    else $warning("l2_pmem_read and l2_pmem_write asserted together");

endmodule
